// File: rtl/cmd_bus_arbiter_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cmd_bus_arbiter_pkg : shared types and constants for the command bus  |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
package cmd_bus_arbiter_pkg;

    localparam int BUS_W = 4;

    localparam logic [BUS_W-1:0] ADDR_CHANNEL = 4'b0010;
    localparam logic [BUS_W-1:0] QUERY        = 4'b1111;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_RELEASE = 2'd2,
        ST_GAP     = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/cmd_bus_arbiter_if.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cmd_bus_arbiter_if : 4-bit command bus between arbiter and processors |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
interface cmd_bus_arbiter_if;
    import cmd_bus_arbiter_pkg::*;

    logic [BUS_W-1:0] address;
    logic [BUS_W-1:0] data;
    logic             valid;
    logic             ack;
    logic [BUS_W-1:0] data_in;
    logic             data_in_valid;

    modport master (
        output address, data, valid,
        input  ack, data_in, data_in_valid
    );

    modport slave (
        input  address, data, valid,
        output ack, data_in, data_in_valid
    );

endinterface
`default_nettype wire

// File: rtl/cmd_bus_arbiter_rr_picker.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cmd_bus_arbiter_rr_picker : round-robin search upward from i_ptr      |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module cmd_bus_arbiter_rr_picker #(
    parameter int N_REQ = 3,
    parameter int PTR_W = 2
) (
    input  wire logic [N_REQ-1:0] i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [PTR_W-1:0] o_win,
    output logic                  o_any
);

    localparam logic [PTR_W:0] C_N = (PTR_W+1)'(N_REQ);

    logic [PTR_W:0] w_sum;

    // Scan from the farthest offset down so the closest requester to i_ptr wins.
    always_comb begin
        o_win = '0;
        o_any = 1'b0;
        w_sum = '0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            w_sum = {1'b0, i_ptr} + (PTR_W+1)'(k);
            if (w_sum >= C_N) begin
                w_sum = w_sum - C_N;
            end
            if (i_req[w_sum[PTR_W-1:0]]) begin
                o_win = w_sum[PTR_W-1:0];
                o_any = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cmd_bus_arbiter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | cmd_bus_arbiter : round-robin owner of the shared 4-bit command bus   |
// | Rev 1.0 - initial release                                             |
// +-----------------------------------------------------------------------+
module cmd_bus_arbiter
    import cmd_bus_arbiter_pkg::*;
#(
    parameter int N_REQ   = 3,
    parameter int TIMEOUT = 15
) (
    input  wire logic                   clk,
    input  wire logic                   rst,
    input  wire logic [N_REQ-1:0]       req,
    input  wire logic [BUS_W*N_REQ-1:0] req_addr,
    input  wire logic [BUS_W*N_REQ-1:0] req_data,
    output logic      [N_REQ-1:0]       done,
    output logic                        err,
    output logic      [BUS_W-1:0]       resp_data,
    output logic      [N_REQ-1:0]       resp_valid,
    cmd_bus_arbiter_if.master           bus
);

    localparam int               PTR_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam logic [7:0]       C_TIMEOUT = 8'(TIMEOUT);
    localparam logic [PTR_W-1:0] C_LAST    = PTR_W'(N_REQ - 1);

    state_t           r_state;
    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] r_win;
    logic [7:0]       r_cnt;
    logic             r_valid;
    logic [BUS_W-1:0] r_addr;
    logic [BUS_W-1:0] r_data;
    logic [N_REQ-1:0] r_done;
    logic             r_err;
    logic [BUS_W-1:0] r_resp_data;
    logic [N_REQ-1:0] r_resp_valid;

    logic [PTR_W-1:0] w_win;
    logic             w_any;
    logic [BUS_W-1:0] w_req_addr [N_REQ];
    logic [BUS_W-1:0] w_req_data [N_REQ];

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_unpack
        assign w_req_addr[gi] = req_addr[gi*BUS_W +: BUS_W];
        assign w_req_data[gi] = req_data[gi*BUS_W +: BUS_W];
    end

    cmd_bus_arbiter_rr_picker #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_picker (
        .i_req (req),
        .i_ptr (r_ptr),
        .o_win (w_win),
        .o_any (w_any)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= ST_IDLE;
            r_ptr        <= '0;
            r_win        <= '0;
            r_cnt        <= '0;
            r_valid      <= 1'b0;
            r_addr       <= '0;
            r_data       <= '0;
            r_done       <= '0;
            r_err        <= 1'b0;
            r_resp_data  <= '0;
            r_resp_valid <= '0;
        end else begin
            r_done       <= '0;
            r_err        <= 1'b0;
            r_resp_valid <= '0;
            case (r_state)
                // GAP is the processor cooldown cycle; arbitration runs at its
                // end so a waiting requester is granted without an extra idle.
                ST_IDLE, ST_GAP: begin
                    if (w_any) begin
                        r_win   <= w_win;
                        r_addr  <= w_req_addr[w_win];
                        r_data  <= w_req_data[w_win];
                        r_cnt   <= '0;
                        r_valid <= 1'b1;
                        r_state <= ST_ISSUE;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_ISSUE: begin
                    r_cnt <= r_cnt + 8'd1;
                    if (bus.ack) begin
                        if (bus.data_in_valid) begin
                            r_resp_data         <= bus.data_in;
                            r_resp_valid[r_win] <= 1'b1;
                        end
                        r_done[r_win] <= 1'b1;
                        r_valid       <= 1'b0;
                        r_state       <= ST_RELEASE;
                    end else if (r_cnt + 8'd1 == C_TIMEOUT) begin
                        r_err         <= 1'b1;
                        r_done[r_win] <= 1'b1;
                        r_valid       <= 1'b0;
                        r_state       <= ST_RELEASE;
                    end
                end
                ST_RELEASE: begin
                    r_ptr   <= (r_win == C_LAST) ? '0 : r_win + 1'b1;
                    r_state <= ST_GAP;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.valid   = r_valid;
    assign bus.address = r_addr;
    assign bus.data    = r_data;
    assign done        = r_done;
    assign err         = r_err;
    assign resp_data   = r_resp_data;
    assign resp_valid  = r_resp_valid;

endmodule
`default_nettype wire

// File: doc/cmd_bus_arbiter.md
# cmd_bus_arbiter

Shares the single 4-bit command bus (address, data, valid, ack) that feeds the channel processor and sibling register processors between several requesters, for example the UART command decoder, the button front-end and the auto-scan timer. Picks one requester round-robin, drives its address/data with a registered valid, waits for ack, and routes any query response back to the issuing requester. A timeout recovers from addresses that no processor decodes.

## Interface
Parameters:
- N_REQ, 3, number of requesters.
- TIMEOUT, 15, maximum cycles from valid asserted to ack before abort (1..255).

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst  in  1  reset, synchronous, active-low.
- req  in  N_REQ  per-requester request level; held until that requester's done.
- req_addr  in  4*N_REQ  address, slice i = [4i+3:4i].
- req_data  in  4*N_REQ  data, same slicing.
- done  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse with done when the transaction timed out.
- resp_data  out  4  latched response value; valid only with resp_valid.
- resp_valid  out  N_REQ  one-cycle pulse, coincident with done, when a response was captured.
- address  out  4  bus address.
- data  out  4  bus data.
- valid  out  1  bus valid.
- ack  in  1  bus ack from the processors, ORed externally.
- data_in  in  4  processor response data.
- data_in_valid  in  1  processor response strobe.

## Operation
- States: IDLE, ISSUE, RELEASE, GAP.
- IDLE: if any req bit is set, choose a winner by round-robin, starting at ptr and searching upward with wrap. Latch the winner index and its address/data into registers. Load the timeout counter with 0 and move to ISSUE. If no req bit is set, stay in IDLE.
- ISSUE: valid=1 and address/data are stable. The counter increments each cycle.
  - On ack=1, capture data_in into resp_data if data_in_valid=1 in the same cycle, then go to RELEASE.
  - If the counter reaches TIMEOUT with no ack, set the error flag and go to RELEASE.
- RELEASE: valid=0. Pulse done[winner], plus err if the error flag is set, plus resp_valid[winner] if a response was captured. Set ptr to winner+1 mod N_REQ. Go to GAP.
- GAP: one idle cycle. This lets the processor's internal ack-cooldown expire. Then go to IDLE.
- Requester rules:
  - Dropping req during a transaction does not abort it; done still pulses.
  - A req still high in the cycle after done is treated as a new request.
- data_in_valid outside ISSUE is ignored.
- Ack in IDLE, RELEASE or GAP is ignored.
- ptr width is clog2(N_REQ). Winner+1 wraps at N_REQ, not at a power of two.

## Timing
- Reset values:
  - state IDLE, ptr 0.
  - valid 0, address 4'h0, data 4'h0.
  - done 0, err 0, resp_valid 0, resp_data 4'h0.
- A reset in any state takes effect on the next edge: valid drops and no done is issued for the aborted transaction.
- All outputs are registered.
- Latencies, with req first sampled high in IDLE at edge t:
  - valid is high from t+1.
  - With the channel processor, which acks one cycle after it samples valid, ack is seen at t+2.
  - valid falls at t+3, done pulses during t+3, and the earliest next valid is at t+5.
- Throughput is one transaction per 4 cycles when ack takes one cycle.
- Timeout: valid stays high for exactly TIMEOUT cycles, then done and err pulse together.
- Simultaneous events:
  - Ack in the same cycle as the counter reaching TIMEOUT counts as success, with err=0.
  - All req bits high at once are served in order ptr, ptr+1, … with no starvation.

## Structure
- Shared package:
  - state enum.
  - Bus address constants, including ADDR_CHANNEL = 4'b0010.
  - Query code QUERY = 4'b1111.
  - Bus width constant 4.
- One sub-module, rr_picker: combinational priority search from ptr with wrap. Outputs the winner index and an any flag.

## Test plan
- Single write: req[0]=1, addr 4'h2, data 4'h1, channel processor attached, SW0=1. Required: valid high for 2 cycles, done[0] pulses, err=0, resp_valid=0, channel becomes 2'b01.
- Query: req[1], addr 4'h2, data 4'hF while channel=2'b01. Required: resp_valid[1] pulses with done[1] and resp_data=4'h1.
- Contention: req=3'b111 held continuously from reset. Required: grants come in order 0,1,2,0, with done pulses 4 cycles apart.
- Timeout: req[2], addr 4'h9 (undecoded), TIMEOUT=15. Required: valid high for 15 cycles, then done[2] and err pulse together, and the next grant goes to requester 0.
- Mid-transaction drops:
  - rst low during ISSUE: next cycle valid=0, state IDLE, no done.
  - req[0] dropped during ISSUE: done[0] still pulses.
- Ack/timeout race: ack on exactly cycle TIMEOUT. Required: err=0.
